pll_lock_supervisor: RTL

Consumes the pixel PLL's `locked` output and drives that PLL's `rst` input. Runs in the PLL reference-clock domain (150 MHz). It pulses the PLL reset, waits for lock with a timeout and bounded retries, and qualifies lock as stable. It then releases a pixel-domain system reset, re-runs the sequence on lock loss, and reports status to the video pipeline and the CSR block.

---
 rtl/pll_lock_supervisor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for lock with a timeout
// and bounded retries, qualifies lock as stable, then releases the
// pixel-domain system reset. A lock loss in RUN restarts the sequence.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 150000,
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2,
    parameter int MAX_RETRIES   = 7
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] loss_count
);

    localparam int MAXP0 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAXP  = (MAXP0 > STABLE_CYCLES) ? MAXP0 : STABLE_CYCLES;
    localparam int CW    = (MAXP < 2) ? 1 : $clog2(MAXP + 1);

    typedef enum logic [2:0] {PRST, WAIT_LOCK, STABLE, RUN, FAULT} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk;
    logic                   fail_now;

    // Output decode for a given state: {pll_rst, sys_rst, ready, fault}.
    // Applied to the destination state so every output is a flop.
    function automatic logic [3:0] outs(input state_t s);
        case (s)
            PRST:      return 4'b1100;
            WAIT_LOCK: return 4'b0100;
            STABLE:    return 4'b0100;
            RUN:       return 4'b0010;
            FAULT:     return 4'b1101;
            default:   return 4'b1100;
        endcase
    endfunction

    // Synchronise the asynchronous PLL lock indicator into refclk.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end

    assign lk = sync_q[SYNC_STAGES-1];

    // A failed attempt: timeout in WAIT_LOCK without lock, or lock dropping
    // while qualifying. Lock on the timeout cycle wins over the timeout.
    always_comb begin
        fail_now = 1'b0;
        if (state == WAIT_LOCK && !lk && cnt == CW'(LOCK_TIMEOUT - 1)) fail_now = 1'b1;
        if (state == STABLE && !lk)                                    fail_now = 1'b1;
    end

    // Sequencer: state, shared counter, retry/loss counts and outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= PRST;
            cnt         <= '0;
            retry_count <= '0;
            loss_count  <= '0;
            {pll_rst, sys_rst, ready, fault} <= outs(PRST);
        end else if (fail_now) begin
            cnt         <= '0;
            retry_count <= retry_count + 4'd1;
            if (retry_count == 4'(MAX_RETRIES - 1)) begin
                state <= FAULT;
                {pll_rst, sys_rst, ready, fault} <= outs(FAULT);
            end else begin
                state <= PRST;
                {pll_rst, sys_rst, ready, fault} <= outs(PRST);
            end
        end else begin
            case (state)
                PRST: begin
                    if (cnt == CW'(RST_CYCLES - 1)) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                        {pll_rst, sys_rst, ready, fault} <= outs(WAIT_LOCK);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state <= STABLE;
                        cnt   <= '0;
                        {pll_rst, sys_rst, ready, fault} <= outs(STABLE);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (cnt == CW'(STABLE_CYCLES - 1)) begin
                        state       <= RUN;
                        cnt         <= '0;
                        retry_count <= '0;
                        {pll_rst, sys_rst, ready, fault} <= outs(RUN);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state <= PRST;
                        cnt   <= '0;
                        if (loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
                        {pll_rst, sys_rst, ready, fault} <= outs(PRST);
                    end
                end
                FAULT: begin
                    cnt <= '0;
                end
                default: begin
                    state <= PRST;
                    cnt   <= '0;
                    {pll_rst, sys_rst, ready, fault} <= outs(PRST);
                end
            endcase
        end
    end

endmodule
